// File: rtl/link_rx_if.sv
// Receive handshake and status bundle between link_rx (master) and the
// link port's serial-data register logic (slave).
interface link_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_irq;
    logic       rx_overrun;
    logic       rx_ferr;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output rx_irq,
        output rx_overrun,
        output rx_ferr
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  rx_irq,
        input  rx_overrun,
        input  rx_ferr
    );
endinterface

// File: rtl/link_rx.sv
// 8N1 UART receive front end for the link port with byte FIFO and valid/ready output.
// Define LINK_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module link_rx #(
    parameter int CLKS_PER_BIT = 36,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clockgb,
    input  logic      reset,
    input  logic      UART_RX,
    link_rx_if.master rx_bus
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("link_rx: CLKS_PER_BIT must be at least 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("link_rx: FIFO_DEPTH must be a power of two, at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             sync1_r;
    logic             rxs_r;
    logic             rxs_d_r;
    logic [2:0]       flush_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             ferr_r;
    logic             irq_r;
    logic             overrun_r;
    logic             rx_valid_r;
    logic [7:0]       rx_data_r;

    logic             edge_s;
    logic             cnt_zero_s;
    logic             push_req_s;
    logic             pop_s;
    logic             accept_s;
    logic             drop_s;
    logic             valid_nxt_s;
    logic [7:0]       head_nxt_s;

    // Two-flop synchroniser, delayed copy for edge detection, and a flush
    // marker so the reset value of the flops is never mistaken for a high line.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxs_d_r <= 1'b1;
            flush_r <= 3'b000;
        end else begin
            sync1_r <= UART_RX;
            rxs_r   <= sync1_r;
            rxs_d_r <= rxs_r;
            flush_r <= {flush_r[1:0], 1'b1};
        end
    end

    assign edge_s     = flush_r[2] & rxs_d_r & ~rxs_r;
    assign cnt_zero_s = (cnt_r == CNT_ZERO);
    assign push_req_s = (state_r == ST_STOP) & cnt_zero_s & rxs_r;
    assign pop_s      = rx_valid_r & rx_bus.rx_ready;
    assign drop_s     = push_req_s & ~accept_s;

    // Frame receiver: mid-bit sampling of start, eight data bits and stop.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            ferr_r  <= 1'b0;
        end else begin
            ferr_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        cnt_r   <= HALF_LOAD;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_zero_s) begin
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r   <= BIT_LOAD;
                            idx_r   <= 3'd0;
                            state_r <= ST_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero_s) begin
                        shift_r[idx_r] <= rxs_r;
                        cnt_r          <= BIT_LOAD;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_zero_s) begin
                        ferr_r  <= ~rxs_r;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LINK_RX_FIFO_EN
    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W:0]   old_left_s;
    logic [PTR_W:0]   count_nxt_s;

    // Next-state of the FIFO; the head register is preloaded with whatever
    // entry will sit at the read pointer after this cycle.
    always_comb begin
        accept_s     = push_req_s & ((count_r != OCC_FULL) | pop_s);
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        old_left_s   = count_r - (pop_s ? OCC_ONE : OCC_ZERO);
        count_nxt_s  = old_left_s + (accept_s ? OCC_ONE : OCC_ZERO);
        valid_nxt_s  = (count_nxt_s != OCC_ZERO);
        if (old_left_s != OCC_ZERO) begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end else if (accept_s) begin
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = rx_data_r;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clockgb) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= OCC_ZERO;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end
`else
    // Single holding register: the output register itself is the storage.
    always_comb begin
        accept_s    = push_req_s & (~rx_valid_r | pop_s);
        valid_nxt_s = accept_s | (rx_valid_r & ~pop_s);
        if (accept_s) begin
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = rx_data_r;
        end
    end
`endif

    // Registered handshake outputs and status flags; a drop outranks a
    // same-cycle pop when deciding the overrun flag.
    always_ff @(posedge clockgb) begin
        if (reset) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            irq_r      <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            rx_data_r  <= head_nxt_s;
            rx_valid_r <= valid_nxt_s;
            irq_r      <= accept_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (pop_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign rx_bus.rx_data    = rx_data_r;
    assign rx_bus.rx_valid   = rx_valid_r;
    assign rx_bus.rx_irq     = irq_r;
    assign rx_bus.rx_overrun = overrun_r;
    assign rx_bus.rx_ferr    = ferr_r;
endmodule

// File: tb/tb_link_rx.sv
// Randomised bench for link_rx: a serial-line driver plus a queue-based
// reference model of frame timing, FIFO occupancy, overrun and framing errors.
module tb_link_rx;
    localparam int CLKS      = 8;
    localparam int DEPTH_CFG = 4;
`ifdef LINK_RX_FIFO_EN
    localparam int MDEPTH = DEPTH_CFG;
`else
    localparam int MDEPTH = 1;
`endif
    // Falling edge to rx_valid: 2 sync + half bit + 9 bits + 1.
    localparam int LAT = 2 + CLKS / 2 + 9 * CLKS + 1;

    typedef struct {
        int unsigned at;
        logic [7:0]  data;
        bit          ferr;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic uart;

    link_rx_if bus ();

    link_rx #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_DEPTH  (DEPTH_CFG)
    ) dut (
        .clockgb(clk),
        .reset  (rst),
        .UART_RX(uart),
        .rx_bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    bit          line_q[$];
    ev_t         ev_q[$];
    logic [7:0]  mq[$];
    bit          m_ovr, m_irq, m_ferr;
    bit          rdy_v;
    int          irq_cnt, ferr_cnt, pop_cnt;
    bit          meas_on, seen_valid;
    int unsigned fall_ref, lat;
    int unsigned pop_at;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue one frame on the line; returns the edge at which its stop bit is sampled.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, output int unsigned at);
        int unsigned n;
        int          b;
        bit          v;
        ev_t         e;
        n = cyc + 1 + line_q.size();
        for (int k = 0; k < 10 * CLKS; k++) begin
            b = k / CLKS;
            if (b == 0) v = 1'b0;
            else if (b == 9) v = stop_ok;
            else v = d[b-1];
            line_q.push_back(v);
        end
        at = n - 1 + LAT;
        e.at = at;
        e.data = d;
        e.ferr = !stop_ok;
        ev_q.push_back(e);
    endtask

    task automatic step();
        bit  pop_m, full_m, drop_m;
        ev_t e;
        uart = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
        bus.rx_ready = rdy_v;
        if (bus.rx_valid === 1'b1 && rdy_v) pop_cnt++;
        @(posedge clk);
        cyc++;
        m_irq  = 1'b0;
        m_ferr = 1'b0;
        if (rst) begin
            mq.delete();
            ev_q.delete();
            m_ovr = 1'b0;
        end else begin
            pop_m  = rdy_v && (mq.size() > 0);
            full_m = (mq.size() == MDEPTH);
            drop_m = 1'b0;
            if (pop_m) void'(mq.pop_front());
            if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                e = ev_q.pop_front();
                if (e.ferr) m_ferr = 1'b1;
                else if (!full_m || pop_m) begin
                    mq.push_back(e.data);
                    m_irq = 1'b1;
                end else drop_m = 1'b1;
            end
            if (drop_m) m_ovr = 1'b1;
            else if (pop_m) m_ovr = 1'b0;
        end
        #1;
        if (bus.rx_irq === 1'b1) irq_cnt++;
        if (bus.rx_ferr === 1'b1) ferr_cnt++;
        if (meas_on && !seen_valid && bus.rx_valid === 1'b1) begin
            seen_valid = 1'b1;
            lat = cyc - fall_ref;
        end
        check_eq("valid", 32'(bus.rx_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) check_eq("data", 32'(bus.rx_data), 32'(mq[0]));
        if (rst) check_eq("rst_data", 32'(bus.rx_data), 32'h0);
        check_eq("irq", 32'(bus.rx_irq), 32'(m_irq));
        check_eq("ferr", 32'(bus.rx_ferr), 32'(m_ferr));
        check_eq("overrun", 32'(bus.rx_overrun), 32'(m_ovr));
    endtask

    // mode: 0 ready low, 1 ready high, 2 sparse random, 3 dense random, 4 only at pop_at.
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       rdy_v = 1'b0;
                1:       rdy_v = 1'b1;
                2:       rdy_v = ($urandom_range(3) == 0);
                3:       rdy_v = ($urandom_range(7) != 0);
                4:       rdy_v = ((cyc + 1) == pop_at);
                default: rdy_v = 1'b0;
            endcase
            step();
        end
    endtask

    initial begin
        int unsigned tmp;
        int          gap;
        bit          ok;
        rst = 1'b1; uart = 1'b1; rdy_v = 1'b0; bus.rx_ready = 1'b0;
        m_ovr = 1'b0; meas_on = 1'b0; seen_valid = 1'b0; lat = 0; pop_at = 0;
        irq_cnt = 0; ferr_cnt = 0; pop_cnt = 0;
        run(2, 0);
        rst = 1'b0;
        run(10, 0);

        // Single byte with latency measurement.
        irq_cnt = 0; seen_valid = 1'b0; lat = 0; meas_on = 1'b1;
        fall_ref = cyc + line_q.size();
        send_frame(8'hA5, 1'b1, tmp);
        run(line_q.size() + 4, 0);
        meas_on = 1'b0;
        check_eq("latency", lat, LAT);
        check_eq("irq_single", irq_cnt, 1);
        check_eq("data_single", 32'(bus.rx_data), 32'hA5);
        run(1, 1);
        check_eq("valid_after_pop", 32'(bus.rx_valid), 32'h0);
        run(4, 0);

        // Back-to-back bytes into a stalled consumer.
        irq_cnt = 0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, tmp);
        run(line_q.size() + 4, 0);
        check_eq("irq_burst", irq_cnt, MDEPTH);
        check_eq("overrun_set", 32'(bus.rx_overrun), 32'h1);
        check_eq("first_byte", 32'(bus.rx_data), 32'h01);
        run(1, 1);
        check_eq("overrun_clear", 32'(bus.rx_overrun), 32'h0);
        run(MDEPTH + 2, 1);

        // Framing error, then the same byte framed correctly.
        irq_cnt = 0; ferr_cnt = 0;
        send_frame(8'h3C, 1'b0, tmp);
        run(line_q.size(), 0);
        for (int i = 0; i < 16; i++) line_q.push_back(1'b1);
        run(16, 0);
        check_eq("ferr_count", ferr_cnt, 1);
        check_eq("ferr_no_irq", irq_cnt, 0);
        send_frame(8'h3C, 1'b1, tmp);
        run(line_q.size() + 2, 0);
        check_eq("after_ferr_irq", irq_cnt, 1);
        check_eq("after_ferr_data", 32'(bus.rx_data), 32'h3C);
        run(2, 1);

        // Short glitch on the line.
        irq_cnt = 0; ferr_cnt = 0;
        line_q.push_back(1'b0);
        line_q.push_back(1'b0);
        run(40, 0);
        check_eq("glitch_irq", irq_cnt, 0);
        check_eq("glitch_ferr", ferr_cnt, 0);

        // Line held low across reset release is not a start bit.
        for (int i = 0; i < 30; i++) line_q.push_back(1'b0);
        rst = 1'b1;
        run(2, 0);
        rst = 1'b0;
        run(line_q.size() + 20, 0);
        check_eq("low_reset_irq", irq_cnt, 0);
        check_eq("low_reset_ferr", ferr_cnt, 0);

        // Reset during bit 4 of 0xFF.
        send_frame(8'hFF, 1'b1, tmp);
        run(44, 0);
        rst = 1'b1;
        line_q.delete();
        run(2, 0);
        rst = 1'b0;
        run(100, 0);
        check_eq("midreset_irq", irq_cnt, 0);
        check_eq("midreset_ferr", ferr_cnt, 0);
        check_eq("midreset_valid", 32'(bus.rx_valid), 32'h0);

        // Full FIFO with a pop landing exactly on the fifth stop-bit sample.
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, tmp);
        send_frame(8'h5A, 1'b1, pop_at);
        run(line_q.size() + 4, 4);
        check_eq("full_pop_overrun", 32'(bus.rx_overrun), 32'h0);
        pop_cnt = 0;
        run(MDEPTH + 6, 1);
        check_eq("full_pop_remaining", pop_cnt, MDEPTH);

        // Randomised traffic, glitches and framing errors.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(9) == 0) begin
                gap = $urandom_range(3, 1);
                for (int i = 0; i < gap; i++) line_q.push_back(1'b0);
                for (int i = 0; i < 12; i++) line_q.push_back(1'b1);
            end
            ok = ($urandom_range(7) != 0);
            send_frame(8'($urandom), ok, tmp);
            gap = ok ? $urandom_range(10) : $urandom_range(12, 2);
            for (int i = 0; i < gap; i++) line_q.push_back(1'b1);
            run(line_q.size(), (f < 20) ? 2 : 3);
        end
        run(MDEPTH * 2 + 10, 1);
        check_eq("drained", 32'(bus.rx_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
